frequency_synth: RTL and testbench

- Programmable pulse-train generator; the transmit-side counterpart of the frequency counter.
- Takes a two-digit BCD edge count and emits exactly that many rising edges on `signal` in every measurement window of (period+1) clocks.
- Distributes the edges evenly using a Bresenham accumulator.
- Drives on-chip self-test of the counter: its `signal` output feeds the counter's `signal` input, with both blocks using the same period.

---
 rtl/frequency_synth.sv | 123 ++++++++++++
 tb/tb_frequency_synth.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_synth.sv
// Programmable pulse-train generator: emits `target` evenly spaced one-cycle
// pulses in every window of update_period+1 clocks using a Bresenham accumulator.
module frequency_synth #(
    parameter int UPDATE_PERIOD = 1200,
    parameter int BITS          = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      ten_count,
    input  logic [3:0]      unit_count,
    input  logic            load,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
    output logic            signal,
    output logic            busy,
    output logic            window_start,
    output logic [6:0]      target
);

    typedef enum logic [1:0] {IDLE, CONVERT, RUN} state_t;

    localparam logic [BITS-1:0] PERIOD_RESET = BITS'(UPDATE_PERIOD);
    localparam logic [BITS:0]   W_RESET      = {1'b0, PERIOD_RESET} + (BITS+1)'(1);

    state_t          state, state_nxt;
    logic [3:0]      tens_rem, units;
    logic [6:0]      sum;
    logic [BITS-1:0] update_period, win_cnt;
    logic [BITS:0]   shadow_w, acc;

    logic [3:0]      ten_clamped, unit_clamped;
    logic [BITS:0]   new_w, w_eff, acc_sum, acc_wrapped;
    logic            pulse, wrap, saturate;
    logic [6:0]      conv_sum, conv_target;

    assign ten_clamped  = (ten_count  > 4'd9) ? 4'd9 : ten_count;
    assign unit_clamped = (unit_count > 4'd9) ? 4'd9 : unit_count;

    // The window length is reloaded at every window start, so the first cycle
    // of a window already uses the freshly loaded period.
    assign new_w       = {1'b0, update_period} + (BITS+1)'(1);
    assign w_eff       = (win_cnt == '0) ? new_w : shadow_w;
    assign acc_sum     = acc + {{(BITS-6){1'b0}}, target};
    assign pulse       = (acc_sum >= w_eff);
    assign acc_wrapped = acc_sum - w_eff;
    assign wrap        = ({1'b0, win_cnt} == (w_eff - (BITS+1)'(1)));

    // Capping N at floor(W/2) keeps at least one low cycle between pulses.
    assign conv_sum    = sum + {3'b000, units};
    assign saturate    = ({{(BITS-7){1'b0}}, conv_sum, 1'b0} > new_w);
    assign conv_target = saturate ? new_w[7:1] : conv_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        window_start = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_nxt = CONVERT;
            end
            CONVERT: begin
                busy = 1'b1;
                if (!load && tens_rem == 4'd0) state_nxt = RUN;
            end
            RUN: begin
                window_start = (win_cnt == '0);
                if (load) state_nxt = CONVERT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_rem      <= '0;
            units         <= '0;
            sum           <= '0;
            target        <= '0;
            acc           <= '0;
            win_cnt       <= '0;
            signal        <= 1'b0;
            update_period <= PERIOD_RESET;
            shadow_w      <= W_RESET;
        end else begin
            signal <= 1'b0;
            if (period_load) update_period <= period;
            if (load) begin
                tens_rem <= ten_clamped;
                units    <= unit_clamped;
                sum      <= '0;
            end else if (state == CONVERT) begin
                if (tens_rem != 4'd0) begin
                    sum      <= sum + 7'd10;
                    tens_rem <= tens_rem - 4'd1;
                end else begin
                    target  <= conv_target;
                    acc     <= '0;
                    win_cnt <= '0;
                end
            end else if (state == RUN) begin
                signal <= pulse;
                if (win_cnt == '0) shadow_w <= new_w;
                // acc is already zero at the wrap; forcing it guards against drift
                if (wrap) begin
                    win_cnt <= '0;
                    acc     <= '0;
                end else begin
                    win_cnt <= win_cnt + BITS'(1);
                    acc     <= pulse ? acc_wrapped : acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_frequency_synth.sv
// Self-checking bench for frequency_synth: vector table, hand-written corner
// sequences and randomized loads checked against an arithmetic pulse model.
module tb_frequency_synth;

    localparam int BITS = 12;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      ten_count = '0;
    logic [3:0]      unit_count = '0;
    logic            load = 1'b0;
    logic [BITS-1:0] period = '0;
    logic            period_load = 1'b0;
    logic            signal, busy, window_start;
    logic [6:0]      target;

    int total = 0;
    int bad = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        int tens;
        int units;
        int per;
        int exp_target;
    } vec_t;

    vec_t vecs[9];

    frequency_synth #(.UPDATE_PERIOD(1200), .BITS(BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .ten_count    (ten_count),
        .unit_count   (unit_count),
        .load         (load),
        .period       (period),
        .period_load  (period_load),
        .signal       (signal),
        .busy         (busy),
        .window_start (window_start),
        .target       (target)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit reached, required run completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: N pulses spread over W cycles; cycle k fires when floor(k*N/W) steps.
    function automatic logic [0:0] model_pulse(input int k, input int n, input int w);
        return (((k + 1) * n) / w) != ((k * n) / w);
    endfunction

    function automatic int model_target(input int t, input int u, input int p);
        int n;
        int w;
        n = 10 * ((t > 9) ? 9 : t) + ((u > 9) ? 9 : u);
        w = p + 1;
        if (2 * n > w) n = w / 2;
        return n;
    endfunction

    // Issues a load (optionally with period_load) and waits out CONVERT.
    task automatic do_load(input int t, input int u, input bit with_pl, input int p,
                           input int exp_busy);
        int cnt;
        ten_count  = 4'(t);
        unit_count = 4'(u);
        load       = 1'b1;
        if (with_pl) begin
            period      = BITS'(p);
            period_load = 1'b1;
        end
        step();
        load        = 1'b0;
        period_load = 1'b0;
        check("convert_signal_low", int'(signal), 0);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            step();
        end
        check("busy_cycles", cnt, exp_busy);
        check("run_entry_window_start", int'(window_start), 1);
    endtask

    // Entered on the first cycle of a window; leaves on the first cycle of the next.
    task automatic check_window(input int n, input int w, input int pl_at, input int pl_val);
        logic s, e, prev;
        int edges = 0;
        int mism = 0;
        int first_bad = -1;
        int ws_bad = 0;
        for (int k = 0; k < w; k++) exp_q.push_back(model_pulse(k, n, w));
        prev = signal;
        for (int k = 0; k < w; k++) begin
            if (k == pl_at) begin
                period      = BITS'(pl_val);
                period_load = 1'b1;
            end
            step();
            period_load = 1'b0;
            s = signal;
            e = exp_q.pop_front();
            if (s !== e) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
            if (s && !prev) edges++;
            prev = s;
            if ((k == w - 1) != (window_start == 1'b1)) ws_bad++;
        end
        check($sformatf("window_pattern(N=%0d,W=%0d,first_bad=%0d)", n, w, first_bad), mism, 0);
        check($sformatf("window_edges(W=%0d)", w), edges, n);
        check($sformatf("window_start_spacing(W=%0d)", w), ws_bad, 0);
    endtask

    initial begin
        int t, u, p, n, act;

        vecs[0] = '{0, 7, 9, 5};
        vecs[1] = '{12, 15, 1200, 99};
        vecs[2] = '{0, 0, 1200, 0};
        vecs[3] = '{9, 9, 0, 0};
        vecs[4] = '{5, 0, 99, 50};
        vecs[5] = '{5, 1, 99, 50};
        vecs[6] = '{3, 3, 64, 32};
        vecs[7] = '{1, 0, 19, 10};
        vecs[8] = '{0, 1, 4095, 1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_signal", int'(signal), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_window_start", int'(window_start), 0);
        check("reset_target", int'(target), 0);
        reset = 1'b0;
        step();

        // default period, 23 edges per 1201-clock window
        do_load(2, 3, 1'b0, 0, 3);
        check("target_23", int'(target), 23);
        repeat (3) check_window(23, 1201, -1, 0);

        // vector table: simultaneous period_load and load
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].tens, vecs[i].units, 1'b1, vecs[i].per,
                    ((vecs[i].tens > 9) ? 9 : vecs[i].tens) + 1);
            check($sformatf("vec%0d_target", i), int'(target), vecs[i].exp_target);
            repeat (2) check_window(vecs[i].exp_target, vecs[i].per + 1, -1, 0);
        end

        // mid-run load of 00 abandons the window
        do_load(9, 9, 1'b1, 1200, 10);
        check("target_99", int'(target), 99);
        check_window(99, 1201, -1, 0);
        repeat (300) step();
        do_load(0, 0, 1'b0, 0, 1);
        check("target_zero", int'(target), 0);
        repeat (2) check_window(0, 1201, -1, 0);

        // period change mid-window takes effect at the next window
        do_load(1, 0, 1'b0, 0, 2);
        check("target_10", int'(target), 10);
        check_window(10, 1201, 600, 599);
        check_window(10, 600, -1, 0);

        // reset during CONVERT
        ten_count  = 4'd9;
        unit_count = 4'd0;
        load       = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        check("busy_before_reset", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_signal", int'(signal), 0);
        check("async_reset_target", int'(target), 0);
        check("async_reset_window_start", int'(window_start), 0);
        @(negedge clk);
        reset = 1'b0;
        act = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (busy || signal || window_start) act++;
        end
        check("idle_after_reset_activity", act, 0);
        // period register must have reverted to 1200
        do_load(0, 1, 1'b0, 0, 1);
        check("target_1_after_reset", int'(target), 1);
        check_window(1, 1201, -1, 0);

        // randomized loads against the model
        for (int i = 0; i < 8; i++) begin
            t = $urandom_range(0, 15);
            u = $urandom_range(0, 15);
            p = $urandom_range(0, 150);
            n = model_target(t, u, p);
            do_load(t, u, 1'b1, p, ((t > 9) ? 9 : t) + 1);
            check($sformatf("rand%0d_target(t=%0d,u=%0d,p=%0d)", i, t, u, p), int'(target), n);
            repeat (2) check_window(n, p + 1, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
